// File: rtl/shift_exec_stage.sv
// ---------------------------------------------------------------------------
// shift_exec_stage
//   Execute-stage shift unit for the RV32I datapath. Handles SLL/SRL/SRA in
//   register and immediate forms as a two-stage pipeline:
//     S1: operand register (operand, 5-bit shamt, decoded op, rd tag)
//     S2: result register toward writeback (out_res, out_rd, out_err)
//   Left shifts reuse the single right shifter by bit-reversing the operand
//   before it and the result after it.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. Valid is never withdrawn by the producer
//   before its transfer, and the payload holds stable while valid && !ready.
//   in_ready depends only on internal state and out_ready, never on in_valid.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   funct3, funct7_5    shift decode (001/0 SLL, 101/0 SRL, 101/1 SRA)
//   is_imm              1: shamt from imm_shamt, 0: shamt from rs2[4:0]
//   rs1, rs2, imm_shamt operand and shift amount sources
//   rd                  destination tag carried to out_rd
//   out_valid/out_ready downstream handshake
//   out_res, out_rd     shift result and its tag
//   out_err             illegal encoding (out_res forced to 0)
// ---------------------------------------------------------------------------
module shift_exec_stage #(
  parameter real T = 0.000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        is_imm,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  imm_shamt,
  input  logic [4:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [4:0]  out_rd,
  output logic        out_err
);

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2,
    OP_ILL = 2'd3
  } op_e;

  function automatic logic [31:0] bitrev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

  // S1 state
  logic        s1_valid;
  logic [31:0] s1_opnd;
  logic [4:0]  s1_shamt;
  op_e         s1_op;
  logic [4:0]  s1_rd;

  // Decode of the incoming operation
  op_e        dec_op;
  logic [4:0] dec_shamt;

  // Only the low five bits of rs2 form a register shift amount.
  logic unused_rs2_hi;
  assign unused_rs2_hi = ^rs2[31:5];

  always_comb begin
    dec_op = OP_ILL;
    if (funct3 == 3'b001 && !funct7_5) begin
      dec_op = OP_SLL;
    end else if (funct3 == 3'b101) begin
      dec_op = funct7_5 ? OP_SRA : OP_SRL;
    end
    dec_shamt = is_imm ? imm_shamt : rs2[4:0];
  end

  // Pipeline control
  logic accept;
  logic s2_load;

  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);

  // Shift datapath, combinational from S1
  logic [31:0] sr_in;
  logic [31:0] sr_out;
  logic        sr_arith;
  logic [31:0] sh_res;

  always_comb begin
    sr_in    = (s1_op == OP_SLL) ? bitrev(s1_opnd) : s1_opnd;
    sr_arith = (s1_op == OP_SRA);
  end

  shift_right32 #(
    .T(T)
  ) u_shift_right32 (
    .a     (sr_in),
    .shamt (s1_shamt),
    .arith (sr_arith),
    .y     (sr_out)
  );

  always_comb begin
    sh_res = sr_out;
    if (s1_op == OP_SLL) begin
      sh_res = bitrev(sr_out);
    end else if (s1_op == OP_ILL) begin
      sh_res = 32'h0;
    end
  end

  // S1 register: a new accept always wins over draining, so S1 stays full
  // when it advances and refills in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_opnd  <= 32'h0;
      s1_shamt <= 5'd0;
      s1_op    <= OP_SLL;
      s1_rd    <= 5'd0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_opnd  <= rs1;
      s1_shamt <= dec_shamt;
      s1_op    <= dec_op;
      s1_rd    <= rd;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 register: payload only changes on a load, so it holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= 32'h0;
      out_rd    <= 5'd0;
      out_err   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_res   <= sh_res;
      out_rd    <= s1_rd;
      out_err   <= (s1_op == OP_ILL);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// shift_right32
//   32-bit logarithmic right shifter. arith = 1 fills vacated bits with a[31],
//   arith = 0 fills with zero. T is a gate-delay annotation carried for
//   timing models; the synthesizable logic is purely combinational.
//
// Ports
//   a      operand
//   shamt  shift amount 0..31
//   arith  1: arithmetic, 0: logical
//   y      shifted result
// ---------------------------------------------------------------------------
module shift_right32 #(
  parameter real T = 0.000
) (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic        arith,
  output logic [31:0] y
);

  if (T < 0.0) begin : g_bad_delay
    $error("shift_right32: gate delay T must be non-negative");
  end

  logic        fill;
  logic [31:0] st [6];

  assign fill  = arith & a[31];
  assign st[0] = a;

  // Stage k shifts by 2**k when shamt[k] is set.
  for (genvar k = 0; k < 5; k++) begin : g_stage
    localparam int N = 1 << k;
    assign st[k+1] = shamt[k] ? {{N{fill}}, st[k][31:N]} : st[k];
  end

  assign y = st[5];

endmodule

// File: tb/tb_shift_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_exec_stage
//   Directed vector table for single operations, then a back-to-back stream
//   with a downstream stall, then an asynchronous reset with two operations
//   in flight.
// ---------------------------------------------------------------------------
module tb_shift_exec_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7_5 = 1'b0;
  logic        is_imm = 1'b0;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic [4:0]  imm_shamt = 5'd0;
  logic [4:0]  rd = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic [4:0]  out_rd;
  logic        out_err;

  shift_exec_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .is_imm    (is_imm),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm_shamt (imm_shamt),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_rd    (out_rd),
    .out_err   (out_err)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [37:0] exp_q[$];  // {err, rd, res}

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference shift: 0 SLL, 1 SRL, 2 SRA, 3 illegal
  function automatic logic [31:0] ref_shift(input int op, input logic [31:0] a, input int sh);
    case (op)
      0:       return a << sh;
      1:       return a >> sh;
      2:       return 32'($signed(a) >>> sh);
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [2:0] f3, input logic f7, input logic imm,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] ish, input logic [4:0] tag);
    in_valid  = 1'b1;
    funct3    = f3;
    funct7_5  = f7;
    is_imm    = imm;
    rs1       = a;
    rs2       = b;
    imm_shamt = ish;
    rd        = tag;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic        f7;
    logic        imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  ish;
    logic [4:0]  tag;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  // One isolated operation: checks one-cycle latency and the result.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    out_ready = 1'b1;
    drive_op(v.f3, v.f7, v.imm, v.a, v.b, v.ish, v.tag);
    #1;
    chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk($sformatf("v%0d_early_valid", idx), 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_valid", idx), 32'(out_valid), 32'd1);
    chk($sformatf("v%0d_res", idx), out_res, v.exp_res);
    chk($sformatf("v%0d_err", idx), 32'(out_err), 32'(v.exp_err));
    chk($sformatf("v%0d_rd", idx), 32'(out_rd), 32'(v.tag));
  endtask

  // ---------------- stream state ----------------
  int          sent, got, occ, cyc;
  logic        saw_drop;
  logic        prev_stall;
  logic [31:0] snap_res;
  logic [4:0]  snap_rd;
  logic        snap_err;

  initial begin
    // Table: f3, f7, imm, rs1, rs2, imm_shamt, rd, expected res, expected err
    vecs[0]  = '{3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0000, 5'd4,  5'd1,  32'hF800_0000, 1'b0};
    vecs[1]  = '{3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0,  5'd2,  32'h0800_0000, 1'b0};
    vecs[2]  = '{3'b001, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0000, 5'd31, 5'd3,  32'h8000_0000, 1'b0};
    vecs[3]  = '{3'b001, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_001F, 5'd0,  5'd4,  32'h1234_5678, 1'b0};
    vecs[4]  = '{3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 5'd3,  5'd7,  32'h0000_0000, 1'b1};
    vecs[5]  = '{3'b001, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 5'd3,  5'd7,  32'h0000_0000, 1'b1};
    vecs[6]  = '{3'b101, 1'b1, 1'b1, 32'h8000_0001, 32'h0000_0000, 5'd31, 5'd8,  32'hFFFF_FFFF, 1'b0};
    vecs[7]  = '{3'b101, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 5'd31, 5'd9,  32'h0000_0000, 1'b0};
    vecs[8]  = '{3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFE0, 5'd7,  5'd10, 32'h8000_0000, 1'b0};
    vecs[9]  = '{3'b101, 1'b0, 1'b1, 32'hF000_0000, 32'h0000_0000, 5'd31, 5'd11, 32'h0000_0001, 1'b0};
    vecs[10] = '{3'b001, 1'b0, 1'b0, 32'h0000_000F, 32'h0000_0024, 5'd0,  5'd12, 32'h0000_00F0, 1'b0};
    vecs[11] = '{3'b101, 1'b1, 1'b0, 32'hF0F0_F0F0, 32'h0000_0008, 5'd0,  5'd13, 32'hFFF0_F0F0, 1'b0};
    vecs[12] = '{3'b101, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0000_0008, 5'd0,  5'd14, 32'h00F0_F0F0, 1'b0};
    vecs[13] = '{3'b111, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0001, 5'd0,  5'd31, 32'h0000_0000, 1'b1};
    vecs[14] = '{3'b001, 1'b0, 1'b1, 32'h8000_0001, 32'h0000_0000, 5'd1,  5'd15, 32'h0000_0002, 1'b0};
    vecs[15] = '{3'b101, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0005, 5'd0,  5'd16, 32'hDEAD_BEEF, 1'b0};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_res", out_res, 32'h0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- vector table ----------------
    for (int i = 0; i < NV; i++) begin
      run_vec(i, vecs[i]);
    end

    // ---------------- back-to-back stream with stall ----------------
    sent = 0; got = 0; occ = 0; cyc = 0;
    saw_drop = 1'b0; prev_stall = 1'b0;
    snap_res = 32'h0; snap_rd = 5'd0; snap_err = 1'b0;
    while (got < 8 && cyc < 100) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 6);
      if (sent < 8) begin
        int op;
        int sh;
        logic [2:0] f3;
        logic       f7;
        logic [31:0] a;
        op = sent % 4;
        sh = (sent * 5 + 3) % 32;
        a  = 32'h8765_4321 + 32'(sent) * 32'h0101_0101;
        f3 = (op == 3) ? 3'b000 : ((op == 0) ? 3'b001 : 3'b101);
        f7 = (op == 2);
        if (sent % 2 == 1) drive_op(f3, f7, 1'b1, a, 32'hFFFF_FFFF, 5'(sh), 5'(sent + 1));
        else               drive_op(f3, f7, 1'b0, a, {27'h5A5A5A5, 5'(sh)}, 5'd0, 5'(sent + 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_res", out_res, snap_res);
        chk("stall_rd", 32'(out_rd), 32'(snap_rd));
        chk("stall_err", 32'(out_err), 32'(snap_err));
      end
      chk($sformatf("stream_in_ready_c%0d", cyc), 32'(in_ready), 32'((occ < 2) || out_ready));
      if (!in_ready) saw_drop = 1'b1;
      if (in_valid && in_ready) begin
        int op;
        op = sent % 4;
        exp_q.push_back({(op == 3), 5'(sent + 1),
                         ref_shift(op, 32'h8765_4321 + 32'(sent) * 32'h0101_0101, (sent * 5 + 3) % 32)});
        sent++;
        occ++;
      end
      if (out_valid && out_ready) begin
        logic [37:0] e;
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("stream_res_%0d", got), out_res, e[31:0]);
          chk($sformatf("stream_rd_%0d", got), 32'(out_rd), 32'(e[36:32]));
          chk($sformatf("stream_err_%0d", got), 32'(out_err), 32'(e[37]));
        end
        got++;
        occ--;
      end
      prev_stall = out_valid && !out_ready;
      snap_res = out_res;
      snap_rd  = out_rd;
      snap_err = out_err;
      cyc++;
    end
    chk("stream_count", 32'(got), 32'd8);
    chk("stream_in_ready_dropped", 32'(saw_drop), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- async reset with two ops in flight ----------------
    out_ready = 1'b0;
    drive_op(3'b101, 1'b0, 1'b1, 32'hF000_0000, 32'h0, 5'd4, 5'd3);
    @(negedge clk);
    drive_op(3'b001, 1'b0, 1'b1, 32'h0000_0003, 32'h0, 5'd2, 5'd5);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_res", out_res, 32'h0F00_0000);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_res", out_res, 32'h0);
    chk("async_rst_rd", 32'(out_rd), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    run_vec(100, '{3'b001, 1'b0, 1'b1, 32'h0000_0003, 32'h0, 5'd2, 5'd5, 32'h0000_000C, 1'b0});
    @(negedge clk);
    #1;
    chk("post_rst_drained", 32'(out_valid), 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
# shift_exec_stage

Execute-stage shift unit for the RV32I datapath. Accepts decoded shift operations (SLL/SRL/SRA and immediate forms), registers operands, drives the `shift_right32` core (left shifts via bit reversal around it), and registers the result toward writeback. Two-stage pipeline with valid/ready handshakes on both sides, throughput one operation per cycle.

## Interface
- `T`, default 0.000: gate delay passed unchanged to the instantiated `shift_right32`.

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream operation present.
- `in_ready` out 1: stage can accept this cycle.
- `funct3` in 3: 001 = SLL, 101 = SRL/SRA; any other value is illegal.
- `funct7_5` in 1: instr[30]; 0 = logical, 1 = arithmetic (legal only with funct3 = 101).
- `is_imm` in 1: 1 = immediate form (shamt from `imm_shamt`), 0 = register form (shamt from `rs2[4:0]`).
- `rs1` in 32: operand to shift.
- `rs2` in 32: register shift amount; bits [31:5] ignored.
- `imm_shamt` in 5: immediate shift amount.
- `rd` in 5: destination register tag, carried through.
- `out_valid` out 1: result present.
- `out_ready` in 1: downstream accepts.
- `out_res` out 32: shift result.
- `out_rd` out 5: tag accompanying `out_res`.
- `out_err` out 1: operation was illegal; `out_res` forced to 0.

## Operation
- Stage S1 (operand register): on accept (`in_valid && in_ready`) captures operand, 5-bit shamt (mux by `is_imm`), op {SLL, SRL, SRA, ILL}, `rd`; sets `s1_valid`.
- Decode: funct3 001 & funct7_5 0 → SLL; 101 & 0 → SRL; 101 & 1 → SRA; anything else → ILL.
- Shift (combinational from S1): SLL feeds `bitrev(rs1)` to `shift_right32` with mode 0 and bit-reverses the output; SRL mode 0; SRA mode 1. One `shift_right32` instance only.
- Stage S2 (result register): captures result, `rd`, error flag when S1 advances; ILL gives res 0, err 1.
- Advance rules: S2 loads when `s1_valid && (!out_valid || out_ready)`. S1 loads on accept. `in_ready = !s1_valid || !out_valid || out_ready`.
- `s1_valid` clears when S1 advances without new accept; `out_valid` clears on `out_valid && out_ready` with no S2 load.
- Simultaneous accept, S1→S2 advance and output handshake in one cycle: all three occur, no bubble.
- Shamt 0: result equals operand for all ops. Shamt 31 SRA: all bits = rs1[31].
- Reset (any time, including mid-operation): `s1_valid`, `out_valid`, `out_err` = 0, `out_res` = 0, `out_rd` = 0; in-flight ops discarded; `in_ready` = 1 after reset.

## Timing
- Latency: op accepted at edge N → `out_valid` high after edge N+1 if downstream not stalled.
- Throughput: 1 op/cycle with `out_ready` held high.
- Stall: while `out_valid && !out_ready`, `out_res`/`out_rd`/`out_err` hold stable; S1 may still hold one op; `in_ready` falls only when both S1 and S2 are full and `out_ready` = 0.
- Capacity: 2 ops in flight; no op lost or duplicated under any `in_valid`/`out_ready` pattern.
- `in_ready` is combinational from state and `out_ready`; no path from `in_valid` to `in_ready`.

## Test plan
- SRA rs1=0x80000000, imm_shamt=4 → out_res=0xF8000000, err 0, out_valid one cycle after accept edge.
- SRL register form rs1=0x80000000, rs2=0xFFFFFFE4 (shamt 4) → 0x08000000; confirms rs2[31:5] ignored.
- SLL rs1=0x00000001 shamt 31 → 0x80000000; SLL rs1=0x12345678 shamt 0 → 0x12345678.
- funct3=000 or (funct3=001, funct7_5=1), rd=7 → out_res 0, out_err 1, out_rd 7.
- Back-to-back 8 ops, out_ready low for 3 cycles mid-stream → in_ready drops only with two ops held, outputs stable while stalled, all 8 results in order with correct rd.
- Assert rst_n low with 2 ops in flight → out_valid 0, out_res 0 immediately (asynchronous); after release, in_ready 1 and new op completes normally.
